// File: rtl/piso_frame_serializer.sv
// ============================================================================
// Module      : piso_frame_serializer
// Description : Parallel-in serial-out word serializer that drives a downstream
//               shift register (d_out / en_out) with a one-cycle done gap.
//               Optional even-parity trailer bit when PISO_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_frame_serializer #(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MSB-1:0] din,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic           dir,
  output logic           d_out,
  output logic           en_out,
  output logic           busy,
  output logic           done
);

`ifdef PISO_PARITY_EN
  localparam int c_NBITS = MSB + 1;
`else
  localparam int c_NBITS = MSB;
`endif
  localparam int                 c_CNT_W = $clog2(MSB + 2);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MSB-1:0]     r_buf;
  logic               r_dir;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_xfer;
  logic               w_last;
  logic               w_bit;

  // Ready is a pure function of state so it never loops back through din_valid.
  assign w_xfer = din_valid && (r_state != S_SHIFT);
  assign w_last = (r_cnt == c_LAST);

`ifdef PISO_PARITY_EN
  localparam logic [c_CNT_W-1:0] c_PAR_IDX = c_CNT_W'(MSB);
  logic r_par;

  assign w_bit = (r_cnt == c_PAR_IDX) ? r_par : (r_dir ? r_buf[0] : r_buf[MSB-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_xfer) begin
      r_par <= ^din;
    end
  end
`else
  assign w_bit = r_dir ? r_buf[0] : r_buf[MSB-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    din_ready = 1'b1;
    en_out    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    d_out     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        din_ready = 1'b0;
        en_out    = 1'b1;
        busy      = 1'b1;
        d_out     = w_bit;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = w_xfer ? S_SHIFT : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The emitted bit always sits at the end selected by the captured order flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
      r_dir <= 1'b0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_buf <= din;
      r_dir <= dir;
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt + 1'b1;
      r_buf <= r_dir ? (r_buf >> 1) : (r_buf << 1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_frame_serializer.sv
// ============================================================================
// Module      : tb_piso_frame_serializer
// Description : Self-checking bench for piso_frame_serializer against a
//               queue-of-future-outputs reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_frame_serializer;

  localparam int W = 16;
`ifdef PISO_PARITY_EN
  localparam int c_NB = W + 1;
`else
  localparam int c_NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         dir;
  logic         d_out;
  logic         en_out;
  logic         busy;
  logic         done;

  piso_frame_serializer #(.MSB(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dir       (dir),
    .d_out     (d_out),
    .en_out    (en_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Each entry is what the outputs show in one future cycle: {en, d, done}.
  logic [2:0] q[$];

  // Collector of observed serial bits for directed word checks.
  logic [W-1:0] acc;
  int           acc_n;

  function automatic logic model_ready();
    return (q.size() == 0) || (q[0][0] == 1'b1);
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] w, input logic dr);
    logic accept;
    logic [4:0] exp_o;
    rst       = r;
    din_valid = v;
    din       = w;
    dir       = dr;
    accept    = !r && v && model_ready();
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (accept) begin
        for (int i = 0; i < W; i++)
          q.push_back({1'b1, dr ? w[i] : w[W-1-i], 1'b0});
`ifdef PISO_PARITY_EN
        q.push_back({1'b1, ^w, 1'b0});
`endif
        q.push_back(3'b001);
      end
    end
    @(negedge clk);
    if (q.size() == 0) exp_o = 5'b10000;
    else exp_o = {model_ready(), q[0][2], q[0][1], q[0][2], q[0][0]};
    chk("outs{rdy,en,d,busy,done}", {27'd0, din_ready, en_out, d_out, busy, done}, {27'd0, exp_o});
    if (en_out) begin
      if (acc_n < W) acc = {acc[W-2:0], d_out};
      acc_n++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, W'($urandom), 1'(($urandom)));
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; din = '0; din_valid = 1'b0; dir = 1'b0;
    acc = '0; acc_n = 0;

    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("reset_ready", {31'd0, din_ready}, 32'd1);

    // MSB-first known word
    acc = '0; acc_n = 0;
    cyc(1'b0, 1'b1, 16'hA5C3, 1'b0);
    idle(c_NB + 3);
    chk("a5c3_msb_bits", {16'd0, acc}, 32'h0000A5C3);
    chk("a5c3_msb_cnt", acc_n, c_NB);

    // LSB-first, dir and din scrambled mid-word
    acc = '0; acc_n = 0;
    cyc(1'b0, 1'b1, 16'hA5C3, 1'b1);
    for (int i = 0; i < c_NB + 3; i++) cyc(1'b0, 1'b0, 16'h1234, 1'(i));
    chk("a5c3_lsb_bits", {16'd0, acc}, 32'h0000C3A5);
    chk("a5c3_lsb_cnt", acc_n, c_NB);

    // Back-to-back: valid held through SHIFT, second word taken at DONE
    acc = '0; acc_n = 0;
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < c_NB + 1; i++) cyc(1'b0, 1'b1, 16'h0001, 1'b0);
    idle(c_NB + 3);
    chk("b2b_first_word", {16'd0, acc}, 32'h0000FFFF);
    chk("b2b_bit_count", acc_n, 2 * c_NB);

    // Reset mid-word: no done pulse afterwards
    cyc(1'b0, 1'b1, 16'h5A5A, 1'b0);
    idle(5);
    cyc(1'b1, 1'b1, 16'h5A5A, 1'b0);
    cyc(1'b1, 1'b1, 16'h5A5A, 1'b0);
    done_seen = 0;
    for (int i = 0; i < c_NB + 3; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0);
      if (done) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);

    // Parity trailer on 16'h0007
    acc = '0; acc_n = 0;
    cyc(1'b0, 1'b1, 16'h0007, 1'b0);
    idle(c_NB + 3);
    chk("p0007_cnt", acc_n, c_NB);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), W'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
